// File: rtl/bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_pkg : shared state encoding and constants for the bus scheduler  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_ACK = 2'd2
    } state_e;

    localparam int   c_DEF_DW    = 16;
    localparam logic c_DATE_IDLE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick, search from ptr+1       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_arbiter
    import bus_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] win_o,
    output logic [IW-1:0]   win_idx_o,
    output logic            any_o
);

    logic [IW-1:0] w_idx;

    always_comb begin
        win_o     = '0;
        win_idx_o = '0;
        any_o     = 1'b0;
        w_idx     = '0;
        for (int off = 1; off <= NREQ; off++) begin
            w_idx = IW'((int'(ptr_i) + off) % NREQ);
            if (!any_o && req_i[w_idx]) begin
                any_o        = 1'b1;
                win_o[w_idx] = 1'b1;
                win_idx_o    = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_sched : round-robin scheduler serialising requester words onto   |
// |             the bus master's date/frame line, with ack timeout       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bus_sched
    import bus_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DW      = c_DEF_DW,
    parameter int TIMEOUT = 255
) (
    input  logic               sclk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] wdata,
    input  logic               ack,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic               err,
    output logic               date,
    output logic               frame
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(DW);
    localparam int CW = 16;
    localparam logic [IW-1:0] c_PTR_RST  = IW'(NREQ - 1);
    localparam logic [BW-1:0] c_BIT_LAST = BW'(DW - 1);
    localparam logic [CW-1:0] c_TO_LAST  = CW'(TIMEOUT - 1);

    state_e            state_q,  state_d;
    logic [NREQ-1:0]   gnt_q,    gnt_d;
    logic [NREQ-1:0]   done_q,   done_d;
    logic              err_q,    err_d;
    logic              date_q,   date_d;
    logic              frame_q,  frame_d;
    logic [DW-1:0]     shift_q,  shift_d;
    logic [IW-1:0]     ptr_q,    ptr_d;
    logic [BW-1:0]     bitcnt_q, bitcnt_d;
    logic [CW-1:0]     tocnt_q,  tocnt_d;

    logic [NREQ-1:0]   w_win;
    logic [IW-1:0]     w_win_idx;
    logic              w_any;
    logic [DW-1:0]     w_word;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .win_o     (w_win),
        .win_idx_o (w_win_idx),
        .any_o     (w_any)
    );

    assign w_word = wdata[int'(w_win_idx) * DW +: DW];

    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            date_q   <= c_DATE_IDLE;
            frame_q  <= 1'b0;
            shift_q  <= '0;
            ptr_q    <= c_PTR_RST;
            bitcnt_q <= '0;
            tocnt_q  <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            date_q   <= date_d;
            frame_q  <= frame_d;
            shift_q  <= shift_d;
            ptr_q    <= ptr_d;
            bitcnt_q <= bitcnt_d;
            tocnt_q  <= tocnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        err_d    = 1'b0;
        date_d   = date_q;
        frame_d  = frame_q;
        shift_d  = shift_q;
        ptr_d    = ptr_q;
        bitcnt_d = bitcnt_q;
        tocnt_d  = tocnt_q;
        case (state_q)
            IDLE: begin
                if (w_any) begin
                    state_d  = SEND;
                    gnt_d    = w_win;
                    shift_d  = w_word;
                    date_d   = w_word[DW-1];
                    frame_d  = 1'b1;
                    ptr_d    = w_win_idx;
                    bitcnt_d = c_BIT_LAST;
                end
            end
            SEND: begin
                // date_q already carries the current MSB; present the next one
                if (bitcnt_q == '0) begin
                    state_d = WAIT_ACK;
                    frame_d = 1'b0;
                    date_d  = c_DATE_IDLE;
                    tocnt_d = '0;
                end else begin
                    shift_d  = shift_q << 1;
                    date_d   = shift_q[DW-2];
                    bitcnt_d = bitcnt_q - 1'b1;
                end
            end
            WAIT_ACK: begin
                if (ack) begin
                    state_d = IDLE;
                    done_d  = gnt_q;
                    gnt_d   = '0;
                end else if (tocnt_q == c_TO_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    gnt_d   = '0;
                end else begin
                    tocnt_d = tocnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                frame_d = 1'b0;
                date_d  = c_DATE_IDLE;
            end
        endcase
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign err   = err_q;
    assign date  = date_q;
    assign frame = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bus_sched : vector table + scoreboard bench for bus_sched         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_bus_sched;

    localparam int TO  = 8;
    localparam int NV  = 11;

    typedef struct {
        logic [3:0]  rq;
        logic [63:0] wd;
        int          ack_dly;   // wait cycles before ack; -1 = never
        logic [3:0]  rq_after;
        logic        ack_send;
    } vec_t;

    typedef struct {
        logic [3:0]  gnt;
        logic [15:0] word;
        bit          ok;
    } exp_t;

    logic        sclk = 1'b0;
    logic        rst;
    logic [3:0]  req, gnt, done;
    logic [63:0] wdata;
    logic        ack, err, date, frame;
    logic [3:0]  req4, gnt4, done4;
    logic [63:0] wd4;
    logic        ack4, err4, date4, frame4;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   mdl_ptr;
    exp_t sb[$];
    vec_t vecs[NV];

    always #5 sclk = ~sclk;

    bus_sched #(.NREQ(4), .DW(16), .TIMEOUT(TO)) dut (
        .sclk(sclk), .rst(rst), .req(req), .wdata(wdata), .gnt(gnt),
        .done(done), .err(err), .date(date), .frame(frame), .ack(ack)
    );

    bus_sched #(.NREQ(4), .DW(16), .TIMEOUT(4)) dut4 (
        .sclk(sclk), .rst(rst), .req(req4), .wdata(wd4), .gnt(gnt4),
        .done(done4), .err(err4), .date(date4), .frame(frame4), .ack(ack4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge sclk);
    endtask

    // Drives one full transaction starting in IDLE on a falling edge.
    task automatic run_txn(input vec_t v);
        exp_t        e, p;
        int          win;
        logic [15:0] got;
        logic [3:0]  act_gnt;
        bit          seen, early, fr_bad;
        win = -1;
        for (int o = 1; o <= 4; o++) begin
            int k;
            k = (mdl_ptr + o) % 4;
            if (win < 0 && v.rq[k]) win = k;
        end
        e.gnt  = 4'(1 << win);
        e.word = v.wd[win*16 +: 16];
        e.ok   = (v.ack_dly >= 0) && (v.ack_dly < TO);
        sb.push_back(e);
        mdl_ptr = win;

        req = v.rq; wdata = v.wd; ack = 1'b0;
        step(1);
        act_gnt = gnt;
        chk("done_one_cycle", {done, 3'b0, err}, 32'h0);
        wdata = ~v.wd; req = v.rq_after; ack = v.ack_send;
        got = '0; early = 0; fr_bad = 0;
        for (int b = 0; b < 16; b++) begin
            if (frame !== 1'b1) fr_bad = 1;
            if (done !== 4'b0 || err !== 1'b0) early = 1;
            got = {got[14:0], date};
            step(1);
        end
        chk("frame_len", fr_bad, 0);
        chk("no_early_done", early, 0);
        chk("frame_end", {frame, date}, 2'b01);
        seen = 0;
        for (int k = 0; k <= TO + 1 && !seen; k++) begin
            ack = (k == v.ack_dly) ? 1'b1 : 1'b0;
            step(1);
            if (done !== 4'b0 || err !== 1'b0) seen = 1;
        end
        ack = 1'b0;
        chk("completion_seen", seen, 1);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            p = sb.pop_front();
            chk("grant", act_gnt, p.gnt);
            chk("serial_word", got, p.word);
            chk("done", done, p.ok ? p.gnt : 4'b0);
            chk("err", err, p.ok ? 1'b0 : 1'b1);
            chk("gnt_cleared", gnt, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{4'b1111, 64'h1234_5678_9ABC_DEF0, 0,  4'b1111, 1'b0};
        vecs[1]  = '{4'b1111, 64'h1234_5678_9ABC_DEF0, 0,  4'b1111, 1'b0};
        vecs[2]  = '{4'b1111, 64'h1234_5678_9ABC_DEF0, 0,  4'b1111, 1'b0};
        vecs[3]  = '{4'b1111, 64'h1234_5678_9ABC_DEF0, 0,  4'b1111, 1'b0};
        vecs[4]  = '{4'b1111, 64'h0F0F_F0F0_8001_7FFE, 0,  4'b0000, 1'b0};
        vecs[5]  = '{4'b0001, 64'hFFFF_0000_1111_A55A, 3,  4'b0000, 1'b0};
        vecs[6]  = '{4'b0010, 64'hCAFE_BEEF_C3C3_0000, -1, 4'b0010, 1'b0};
        vecs[7]  = '{4'b0100, 64'h0000_5A5A_FFFF_0001, 7,  4'b0000, 1'b0};
        vecs[8]  = '{4'b1000, 64'h8421_0000_0000_0000, 0,  4'b0000, 1'b1};
        vecs[9]  = '{4'b0110, 64'h0000_3C3C_6996_0000, 1,  4'b0110, 1'b0};
        vecs[10] = '{4'b1001, 64'hBEEF_0000_0000_1357, 2,  4'b0000, 1'b0};

        rst = 1'b0; req = '0; wdata = '0; ack = 1'b0;
        req4 = '0; wd4 = '0; ack4 = 1'b0;
        mdl_ptr = 3;
        step(2);
        chk("reset_outputs", {gnt, done, err, frame, date}, {4'b0, 4'b0, 3'b001});
        chk("reset_outputs4", {gnt4, done4, err4, frame4, date4}, {4'b0, 4'b0, 3'b001});
        rst = 1'b1;
        step(2);

        for (int i = 0; i < NV; i++) run_txn(vecs[i]);

        // Abort mid-frame, then confirm the pointer restarted at requester 0.
        req = 4'b0010; wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        step(1);
        chk("abort_grant", gnt, 4'b0010);
        req = '0;
        step(5);
        chk("abort_in_frame", frame, 1);
        rst = 1'b0;
        #1;
        chk("abort_async", {gnt, frame, date}, {4'b0, 2'b01});
        step(1);
        rst = 1'b1;
        mdl_ptr = 3;
        run_txn('{4'b0101, 64'h0000_7777_0000_1E1E, 0, 4'b0000, 1'b0});
        run_txn('{4'b0100, 64'h0000_2468_0000_0000, 0, 4'b0000, 1'b0});

        // TIMEOUT=4: ack on the 4th wait cycle wins over the timeout.
        req4 = 4'b0001; wd4 = 64'h0000_0000_0000_F00F;
        step(1);
        chk("t4_grant", gnt4, 4'b0001);
        req4 = '0;
        step(16);
        chk("t4_frame_end", frame4, 0);
        for (int i = 0; i < 4; i++) begin
            ack4 = (i == 3) ? 1'b1 : 1'b0;
            step(1);
        end
        ack4 = 1'b0;
        chk("t4_ack_wins_done", done4, 4'b0001);
        chk("t4_ack_wins_err", err4, 0);
        step(1);
        req4 = 4'b0010;
        step(1);
        chk("t4_grant2", gnt4, 4'b0010);
        req4 = '0;
        step(19);
        chk("t4_no_err_early", err4, 0);
        step(1);
        chk("t4_timeout", {err4, done4, gnt4}, {1'b1, 8'h00});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_sched.md
Name: bus_sched

Overview:
- Round-robin scheduler that shares the single serial transmit path (serial `date` line into the bus master, `ack` back) among NREQ requesters.
- Each requester presents a DW-bit word. The scheduler grants one requester, latches its word and shifts it out MSB-first on `date` with a framing strobe.
- It then waits for the master's `ack`, reports per-requester completion, or flags a timeout error.
- Sits between client logic and the serial bus master in the top-level bus design.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 16, word width shifted per transaction (matches the 16-bit receiver output).
- TIMEOUT, 255, max cycles to wait for ack after the last data bit (1..65535).

Ports:
- sclk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request level.
- wdata  in  NREQ*DW  requester words; requester i occupies bits [i*DW +: DW].
- gnt  out  NREQ  one-hot grant, held for the whole transaction.
- done  out  NREQ  one-cycle pulse on the granted bit when ack is received.
- err  out  1  one-cycle pulse on ack timeout.
- date  out  1  serial data to bus master; idles high.
- frame  out  1  high exactly while the DW data bits are on `date`.
- ack  in  1  transaction-accepted indication from bus master.

Behaviour:
- Reset (rst=0, async) values:
  - gnt=0, done=0, err=0, frame=0, date=1.
  - State=IDLE, timeout counter=0.
  - RR pointer = NREQ-1, so requester 0 has first priority.
- States are IDLE, SEND, WAIT_ACK.
- IDLE:
  - If any req is high at edge N, the winner is selected combinationally by round-robin: search starts at pointer+1 and wraps modulo NREQ.
  - At edge N the block sets gnt[winner]=1, loads shift reg with wdata[winner], sets pointer=winner, sets bit counter=DW-1, and enters SEND.
  - If no req is high, the block stays in IDLE with outputs at idle values.
- SEND:
  - date=shift_reg MSB and frame=1 for exactly DW cycles, starting the cycle after edge N. Bit DW-1 goes out first, bit 0 last.
  - Shift left one bit per cycle.
  - After the cycle carrying bit 0: frame=0, date=1, counter cleared, enter WAIT_ACK.
  - ack is ignored in SEND.
- WAIT_ACK:
  - ack sampled high is accepted on any cycle, including the first. On acceptance, at that edge: done[granted]=1 for one cycle, gnt=0, enter IDLE.
  - Otherwise the counter increments. On the edge where the counter reaches TIMEOUT-1 with ack still low: err=1 for one cycle, no done, gnt=0, enter IDLE.
  - ack and timeout on the same edge: ack wins (done, no err).
- Minimum spacing: one IDLE cycle between transactions, so back-to-back grants are separated by that one cycle.
- req deasserted mid-transaction is ignored; the transaction completes. wdata changes after grant are ignored because the word is latched.
- A requester holding req continuously gets served again only after every other active requester has been served once (fairness).
- Reset asserted mid-frame: everything returns to reset values immediately and the frame is aborted. frame drops asynchronously, so the master must treat a frame shorter than DW bits as invalid.
- Outputs gnt, done, err, date, frame are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package `bus_pkg`:
  - state encoding (IDLE=2'd0, SEND=2'd1, WAIT_ACK=2'd2);
  - default DW=16;
  - idle level of `date` (1'b1).
- One natural sub-module: `rr_arbiter`.
  - Inputs: req and pointer.
  - Output: one-hot winner plus its index.
  - Purely combinational.
- The FSM, shift register and timeout counter stay in bus_sched.

Test Plan:
- Single request: req=4'b0001, wdata[15:0]=16'hA55A; ack pulsed 3 cycles after frame falls.
  - gnt=0001 one cycle after req.
  - date carries 1010010101011010 under 16 frame-high cycles.
  - done=0001 one cycle; gnt clears.
- Fairness: req=4'b1111 held, ack returned immediately each time.
  - Grant order 0,1,2,3,0.
  - Exactly one IDLE cycle between grants.
- Timeout: TIMEOUT=8, ack held low after frame.
  - err pulses on the 8th WAIT_ACK cycle.
  - done stays 0; gnt clears; the next request is served normally.
- Reset mid-frame: rst=0 after 5 data bits.
  - Immediately: frame=0, date=1, gnt=0.
  - After release, req2 alone is granted first (pointer reset → priority from 0).
- Noise/withdrawal: ack=1 during SEND and req dropped during SEND.
  - No early done.
  - Full 16 bits are sent; done is issued on the first ack in WAIT_ACK.
- Simultaneous ack at timeout edge (TIMEOUT=4, ack on 4th wait cycle) → done pulses, err stays 0.
